// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode encodings, opcode field position,
// fetch FSM states and the decoder result type.
package cpu_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [5:0] OP_ADD  = 6'd4;
    localparam logic [5:0] OP_AND  = 6'd25;
    localparam logic [5:0] OP_MOVL = 6'd11;
    localparam logic [5:0] OP_MOVS = 6'd13;
    localparam logic [5:0] OP_JA   = 6'd14;
    localparam logic [5:0] OP_CMP  = 6'd59;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] onehot;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational 6-to-64 one-hot opcode decode with an unsupported-opcode flag.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec.onehot  = 64'd1 << opcode;
        dec.illegal = !(opcode inside {OP_ADD, OP_AND, OP_MOVL, OP_MOVS, OP_JA, OP_CMP});
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// Front-end fetch/decode stage: PC, imem req/ack handshake, instruction latch,
// one-hot opcode decode, stall hold and jump redirect with in-flight squash.
module fetch_decode_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [63:0] op_onehot,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        dec_valid,
    output logic        illegal_op
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  tgt;
    logic         run;
    logic         accept;
    logic         consume;
    logic         pending;
    dec_t         dec;

    opcode_decoder u_dec (
        .opcode (imem_rdata[OPCODE_MSB:OPCODE_LSB]),
        .dec    (dec)
    );

    // run gates the request so it stays low through reset and rises one cycle later
    assign imem_req  = run && (state != HOLD);
    assign imem_addr = pc;
    assign pending   = imem_req && !imem_ack;
    assign accept    = imem_req && imem_ack && (state == FETCH) && !redirect;
    assign consume   = dec_valid && !stall;

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = pending ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH:   if (accept) state_nxt = stall ? HOLD : FETCH;
                HOLD:    if (!stall) state_nxt = FETCH;
                DRAIN:   if (imem_ack) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            run        <= 1'b0;
            pc         <= RESET_PC;
            tgt        <= RESET_PC;
            dec_valid  <= 1'b0;
            op_onehot  <= '0;
            illegal_op <= 1'b0;
            instr_out  <= '0;
            pc_out     <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (redirect) begin
                dec_valid  <= 1'b0;
                op_onehot  <= '0;
                illegal_op <= 1'b0;
                // keep pc as the live address until the outstanding request is acked
                if (pending) tgt <= redirect_pc;
                else         pc  <= redirect_pc;
            end else if (accept) begin
                instr_out  <= imem_rdata;
                pc_out     <= pc;
                op_onehot  <= dec.onehot;
                illegal_op <= dec.illegal;
                dec_valid  <= 1'b1;
                pc         <= pc + 32'(PC_STEP);
            end else begin
                if (state == DRAIN && imem_ack) pc <= tgt;
                if (consume) begin
                    dec_valid  <= 1'b0;
                    op_onehot  <= '0;
                    illegal_op <= 1'b0;
                end
            end
        end
    end

endmodule
